sensor_monitor_ctrl: RTL

Periodic sampling and alarm controller for the 4-input sensor error rule. It synchronizes the raw sensor bus and evaluates the error rule once per sample period. An alarm is raised only after DEBOUNCE consecutive faulty samples. The alarm is latched until the host acknowledges it and the fault has cleared. It sits between the raw sensor pins and the host status/interrupt logic.

---
 rtl/sensor_pkg.sv | 27 ++
 rtl/sample_timer.sv | 40 ++++
 rtl/sensor_monitor_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared types, constants and the sensor error rule
//
// Contents:
//   state_t      - monitor FSM state encoding (IDLE, MONITOR, PENDING, ALARM)
//   NUM_SENSORS  - width of the sensor bus
//   DCNT_W       - width of the consecutive-fault (debounce) counter
//   sensor_err() - combinational error rule on the synchronized sensor bus

package sensor_pkg;

    localparam int NUM_SENSORS = 4;
    localparam int DCNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        PENDING = 2'd2,
        ALARM   = 2'd3
    } state_t;

    // Sensor 0 is a fault on its own; sensor 1 is only a fault when it is
    // corroborated by sensor 2 or sensor 3.
    function automatic logic sensor_err(input logic [NUM_SENSORS-1:0] s);
        return s[0] | (s[1] & s[2]) | (s[1] & s[3]);
    endfunction

endpackage

// File: rtl/sample_timer.sv
// rtl/sample_timer.sv - free-running sample period timer with strobe output
//
// Ports:
//   clk    in   system clock
//   n_rst  in   asynchronous active-low reset
//   run    in   1 = count, 0 = hold the count at 0
//   strobe out  registered one-cycle pulse, once every SAMPLE_PERIOD cycles
//
// The count runs 0..SAMPLE_PERIOD-1 and wraps. The strobe flop is loaded from
// the terminal count, so after run rises the first strobe appears
// SAMPLE_PERIOD cycles later and then repeats every SAMPLE_PERIOD cycles.

module sample_timer #(
    parameter int SAMPLE_PERIOD = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic run,
    output logic strobe
);

    localparam int TW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [TW-1:0] LAST = TW'(SAMPLE_PERIOD - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count  <= '0;
            strobe <= 1'b0;
        end else if (!run) begin
            count  <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= (count == LAST);
            count  <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/sensor_monitor_ctrl.sv
// rtl/sensor_monitor_ctrl.sv - periodic sensor sampling, debounce and latched alarm
//
// Ports:
//   clk            in   system clock
//   n_rst          in   asynchronous active-low reset
//   enable         in   level, 1 = monitoring active
//   sensors        in   raw asynchronous sensor inputs
//   alarm_ack      in   level, host acknowledge of the latched alarm
//   sample_strobe  out  one-cycle pulse on each sample instant
//   alarm          out  latched alarm, high while the FSM is in ALARM
//   alarm_snapshot out  synchronized sensor value captured on the alarming sample
//   error_count    out  number of ALARM entries, saturating
//
// Sampling decisions are taken only on strobe cycles; enable and the
// acknowledge are acted on in any cycle.

module sensor_monitor_ctrl
    import sensor_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 10,
    parameter int DEBOUNCE      = 3,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensors,
    input  logic                   alarm_ack,
    output logic                   sample_strobe,
    output logic                   alarm,
    output logic [NUM_SENSORS-1:0] alarm_snapshot,
    output logic [CNT_W-1:0]       error_count
);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t                 state;
    logic [DCNT_W-1:0]      dcnt;
    logic [NUM_SENSORS-1:0] sync_q1;
    logic [NUM_SENSORS-1:0] s;
    logic                   err;
    logic                   run;
    logic                   enter_alarm;

    // Two-flop synchronizer; every bit is sampled on the same edge so a
    // multi-bit change lands in s as one word (give or take metastability).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q1 <= '0;
            s       <= '0;
        end else begin
            sync_q1 <= sensors;
            s       <= sync_q1;
        end
    end

    assign err = sensor_err(s);
    assign run = (state != IDLE);

    sample_timer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_sample_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .run   (run),
        .strobe(sample_strobe)
    );

    // A faulty strobe completes the debounce either straight from MONITOR
    // (DEBOUNCE of 1) or from PENDING once DEBOUNCE-1 faults are already
    // counted. Dropping enable on the same cycle suppresses it.
    always_comb begin
        enter_alarm = 1'b0;
        if (enable && sample_strobe && err) begin
            if ((state == MONITOR) && (DEBOUNCE == 1)) begin
                enter_alarm = 1'b1;
            end
            if ((state == PENDING) && (dcnt == DCNT_LAST)) begin
                enter_alarm = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= IDLE;
            dcnt           <= '0;
            alarm          <= 1'b0;
            alarm_snapshot <= '0;
            error_count    <= '0;
        end else if (enter_alarm) begin
            state          <= ALARM;
            alarm          <= 1'b1;
            alarm_snapshot <= s;
            dcnt           <= '0;
            if (error_count != CNT_MAX) begin
                error_count <= error_count + 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    dcnt <= '0;
                    if (enable) begin
                        state <= MONITOR;
                    end
                end
                MONITOR: begin
                    if (!enable) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (sample_strobe && err) begin
                        dcnt  <= DCNT_W'(1);
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (!enable) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (sample_strobe) begin
                        if (err) begin
                            dcnt <= dcnt + 1'b1;
                        end else begin
                            // Faults must be consecutive: one clean sample restarts.
                            dcnt  <= '0;
                            state <= MONITOR;
                        end
                    end
                end
                ALARM: begin
                    // Ack is only honoured once the fault has gone; enable
                    // alone never releases the alarm.
                    if (alarm_ack && !err) begin
                        alarm <= 1'b0;
                        state <= enable ? MONITOR : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    alarm <= 1'b0;
                    dcnt  <= '0;
                end
            endcase
        end
    end

endmodule
